// File: rtl/mtpsa_pkg.sv
// Shared constants and types for the multi-tenant SUME pipeline front end.
package mtpsa_pkg;

    // Field positions inside the SUME TUSER metadata word
    localparam int unsigned PKT_LEN_LSB  = 0;
    localparam int unsigned SRC_PORT_LSB = 16;
    localparam int unsigned DST_PORT_LSB = 24;
    localparam int unsigned USER_ID_LSB  = 32;
    localparam int unsigned SEND_DIG_LSB = 40;
    localparam int unsigned USER_ID_W    = 8;

    // Arbiter states: IDLE arbitrates, XFER forwards one locked packet
    typedef enum logic {
        IDLE,
        XFER
    } arb_state_e;

endpackage

// File: rtl/mtpsa_axis_skid.sv
// Two-entry AXI-Stream register slice; upstream ready is a pure flop output.
module mtpsa_axis_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // Ready only depends on skid occupancy, so it never sees out_ready combinationally
    assign in_ready  = ~skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Move beats between input, output register and skid register
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            if (out_ready) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_ready) begin
            out_valid_d = in_valid;
            if (in_valid) begin
                out_data_d = in_data;
            end
        end else if (in_valid) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // Slice registers, flushed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/mtpsa_user_arbiter.sv
// Packet-granular round-robin arbiter sharing one ingress pipeline between tenants.
module mtpsa_user_arbiter
    import mtpsa_pkg::*;
#(
    parameter int unsigned NUM_USERS   = 4,
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned TUSER_WIDTH = 128,
    parameter int unsigned USER_ID_LSB = mtpsa_pkg::USER_ID_LSB
) (
    input  logic                              clk_line,
    input  logic                              clk_line_rst,
    input  logic [NUM_USERS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_USERS*DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_USERS*TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_USERS-1:0]              s_axis_tvalid,
    output logic [NUM_USERS-1:0]              s_axis_tready,
    input  logic [NUM_USERS-1:0]              s_axis_tlast,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]            m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic [NUM_USERS-1:0]              user_enable,
    output logic [7:0]                        active_user,
    output logic                              busy
);

    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
    localparam int unsigned PAY_W  = DATA_WIDTH + KEEP_W + TUSER_WIDTH + 1;

    arb_state_e             state_q, state_d;
    logic [7:0]             last_grant_q, last_grant_d;
    logic [7:0]             active_user_q, active_user_d;
    logic                   busy_q, busy_d;
    logic [NUM_USERS-1:0]   req;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_W-1:0]      sel_keep;
    logic [TUSER_WIDTH-1:0] sel_user;
    logic                   slice_valid;
    logic                   slice_ready;
    logic [PAY_W-1:0]       slice_out;

    // First requester strictly after last_i, wrapping to the lowest index
    function automatic logic [7:0] rr_pick(input logic [NUM_USERS-1:0] req_i,
                                           input logic [7:0]           last_i);
        logic [7:0] pick;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_USERS; j++) begin
            if (!found && req_i[j] && (8'(j) > last_i)) begin
                pick  = 8'(j);
                found = 1'b1;
            end
        end
        for (int j = 0; j < NUM_USERS; j++) begin
            if (!found && req_i[j]) begin
                pick  = 8'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Grant mux, user_id stamping and next-state logic
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        active_user_d = active_user_q;
        busy_d        = busy_q;
        s_axis_tready = '0;
        slice_valid   = 1'b0;
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_data      = '0;
        sel_keep      = '0;
        sel_user      = '0;
        req           = s_axis_tvalid & user_enable;

        for (int i = 0; i < NUM_USERS; i++) begin
            if (active_user_q == 8'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                sel_user  = s_axis_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
            end
        end
        sel_user[USER_ID_LSB +: USER_ID_W] = active_user_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    active_user_d = rr_pick(req, last_grant_q);
                    state_d       = XFER;
                    busy_d        = 1'b1;
                end
            end
            XFER: begin
                for (int i = 0; i < NUM_USERS; i++) begin
                    s_axis_tready[i] = slice_ready && (active_user_q == 8'(i));
                end
                slice_valid = sel_valid;
                if (sel_valid && slice_ready && sel_last) begin
                    last_grant_d = active_user_q;
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter registers
    always_ff @(posedge clk_line) begin
        if (clk_line_rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 8'(NUM_USERS - 1);
            active_user_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            active_user_q <= active_user_d;
            busy_q        <= busy_d;
        end
    end

    mtpsa_axis_skid #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk_line),
        .rst       (clk_line_rst),
        .in_data   ({sel_data, sel_keep, sel_user, sel_last}),
        .in_valid  (slice_valid),
        .in_ready  (slice_ready),
        .out_data  (slice_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = slice_out;
    assign active_user = active_user_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mtpsa_user_arbiter.sv
// Self-checking bench: per-tenant sources, per-tenant scoreboard, directed plus random traffic.
module tb_mtpsa_user_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic            clk_line = 1'b0;
    logic            clk_line_rst = 1'b1;
    logic [N*DW-1:0] s_axis_tdata = '0;
    logic [N*KW-1:0] s_axis_tkeep = '0;
    logic [N*UW-1:0] s_axis_tuser = '0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N-1:0]    s_axis_tready;
    logic [N-1:0]    s_axis_tlast = '0;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic [N-1:0]    user_enable = '1;
    logic [7:0]      active_user;
    logic            busy;

    mtpsa_user_arbiter dut (
        .clk_line      (clk_line),
        .clk_line_rst  (clk_line_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .user_enable   (user_enable),
        .active_user   (active_user),
        .busy          (busy)
    );

    initial forever #5 clk_line = ~clk_line;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    beat_t      src_q[N][$];
    beat_t      exp_q[N][$];
    int         acc_cnt[N];
    int         seq_no[N];
    int         pkt_order[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         cur_user = -1;
    int         span_first = -1;
    int         span_last = 0;
    int         out_beats = 0;
    int         rmode = 0;
    bit         gap_en = 1'b0;
    bit         hold_pend = 1'b0;
    beat_t      hold_b;
    logic [7:0] last_uid = '0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_d();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] rnd_u();
        logic [UW-1:0] r;
        for (int k = 0; k < UW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected egress form of a beat: the tenant index replaces the user_id byte
    function automatic beat_t stamp(input beat_t b, input int u);
        beat_t r;
        r = b;
        r.u[39:32] = 8'(u);
        return r;
    endfunction

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += src_q[i].size() + exp_q[i].size();
        return s;
    endfunction

    // Present each source's head beat; a beat offered but not taken is held unchanged
    task automatic drive(input logic [N-1:0] hs);
        for (int i = 0; i < N; i++) begin
            if (s_axis_tvalid[i] && !hs[i]) continue;
            if (src_q[i].size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                s_axis_tvalid[i]           = 1'b1;
                s_axis_tdata[i*DW +: DW]   = src_q[i][0].d;
                s_axis_tkeep[i*KW +: KW]   = src_q[i][0].k;
                s_axis_tuser[i*UW +: UW]   = src_q[i][0].u;
                s_axis_tlast[i]            = src_q[i][0].l;
            end else begin
                s_axis_tvalid[i] = 1'b0;
            end
        end
    endtask

    task automatic add_pkt(input int u, input int len, input logic [7:0] uid);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d        = rnd_d();
            b.d[15:0]  = {8'(seq_no[u]), 8'(u)};
            b.k        = $urandom;
            b.u        = rnd_u();
            b.u[39:32] = uid;
            b.l        = (k == len - 1);
            seq_no[u]++;
            src_q[u].push_back(b);
        end
        drive('0);
    endtask

    // Scoreboard one egress beat against the head of its tenant's queue
    task automatic out_beat(input beat_t ob);
        int u;
        u = int'(ob.d[7:0]);
        chk("uid_range", 512'(u < N), 512'(1));
        if (u >= N) return;
        if (cur_user < 0) pkt_order.push_back(u);
        else chk("contiguous", 512'(u), 512'(cur_user));
        if (span_first < 0) span_first = cyc;
        span_last = cyc;
        out_beats++;
        last_uid = ob.u[39:32];
        chk("beat_expected", 512'(exp_q[u].size() != 0), 512'(1));
        if (exp_q[u].size() != 0) begin
            chk("beat_content", 512'(ob), 512'(exp_q[u][0]));
            void'(exp_q[u].pop_front());
        end
        cur_user = ob.l ? -1 : u;
    endtask

    // One clock: sample handshakes before the edge, update models and stimulus after it
    task automatic cycle();
        logic [N-1:0] hs;
        logic         ohs;
        beat_t        ob;
        hs  = clk_line_rst ? '0 : (s_axis_tvalid & s_axis_tready);
        ohs = !clk_line_rst && m_axis_tvalid && m_axis_tready;
        ob  = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
        if (!clk_line_rst && hold_pend)
            chk("stable_hold", 512'({m_axis_tvalid, ob}), 512'({1'b1, hold_b}));
        hold_pend = !clk_line_rst && m_axis_tvalid && !m_axis_tready;
        hold_b    = ob;
        if (ohs) out_beat(ob);
        @(posedge clk_line);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                exp_q[i].push_back(stamp(src_q[i][0], i));
                void'(src_q[i].pop_front());
                acc_cnt[i]++;
            end
        end
        drive(hs);
        case (rmode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while (pending() != 0 && b < budget) begin
            cycle();
            b++;
        end
        chk("drain_left", 512'(pending()), 512'(0));
    endtask

    initial begin
        int base;
        int a0;
        int b;
        int n0;
        int n2;
        int en_exp1[8];
        int en_exp2[4];

        // Reset state
        @(posedge clk_line);
        #1;
        chk("rst_mvalid", 512'(m_axis_tvalid), 512'(0));
        chk("rst_mlast", 512'(m_axis_tlast), 512'(0));
        chk("rst_sready", 512'(s_axis_tready), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_active", 512'(active_user), 512'(0));
        chk("rst_mpayload", 512'({m_axis_tdata, m_axis_tkeep, m_axis_tuser}), 512'(0));
        @(posedge clk_line);
        #1;
        clk_line_rst = 1'b0;

        // All four tenants with 3-beat packets: strict 0,1,2,3 with one bubble each
        base = pkt_order.size();
        span_first = -1;
        a0 = out_beats;
        for (int u = 0; u < N; u++) add_pkt(u, 3, 8'($urandom));
        drain(200);
        for (int k = 0; k < N; k++)
            chk("rr_order", 512'(pkt_order[base+k]), 512'(k));
        chk("rr_beats", 512'(out_beats - a0), 512'(12));
        chk("rr_span", 512'(span_last - span_first + 1), 512'(15));

        // Single requester with a forged user_id byte
        base = pkt_order.size();
        span_first = -1;
        add_pkt(2, 3, 8'hAB);
        add_pkt(2, 3, 8'hAB);
        drain(200);
        chk("single_order0", 512'(pkt_order[base]), 512'(2));
        chk("single_order1", 512'(pkt_order[base+1]), 512'(2));
        chk("single_uid", 512'(last_uid), 512'(8'h02));
        chk("single_span", 512'(span_last - span_first + 1), 512'(7));

        // Output held off: only two beats enter the slice
        rmode = 2;
        m_axis_tready = 1'b0;
        base = acc_cnt[3];
        add_pkt(3, 6, 8'($urandom));
        repeat (10) cycle();
        chk("hold_accepted", 512'(acc_cnt[3] - base), 512'(2));
        chk("hold_sready", 512'(s_axis_tready[3]), 512'(0));
        chk("hold_mvalid", 512'(m_axis_tvalid), 512'(1));
        chk("hold_busy", 512'(busy), 512'(1));
        rmode = 0;
        m_axis_tready = 1'b1;
        drain(200);
        chk("hold_total", 512'(acc_cnt[3] - base), 512'(6));

        // Admission mask 1011, then tenant 0 disabled in the middle of its second packet
        user_enable = 4'b1011;
        base = pkt_order.size();
        a0 = acc_cnt[0];
        for (int p = 0; p < 3; p++)
            for (int u = 0; u < N; u++) add_pkt(u, 4, 8'($urandom));
        b = 0;
        while (acc_cnt[0] - a0 < 5 && b < 200) begin
            cycle();
            b++;
        end
        chk("en_mid_pkt", 512'(acc_cnt[0] - a0), 512'(5));
        user_enable = 4'b1010;
        repeat (80) cycle();
        en_exp1 = '{0, 1, 3, 0, 1, 3, 1, 3};
        chk("en_count", 512'(pkt_order.size() - base), 512'(8));
        for (int k = 0; k < 8 && base + k < pkt_order.size(); k++)
            chk("en_order", 512'(pkt_order[base+k]), 512'(en_exp1[k]));
        n0 = src_q[0].size();
        n2 = src_q[2].size();
        chk("en_left0", 512'(n0), 512'(4));
        chk("en_left2", 512'(n2), 512'(12));
        user_enable = '1;
        base = pkt_order.size();
        drain(400);
        en_exp2 = '{0, 2, 2, 2};
        for (int k = 0; k < 4 && base + k < pkt_order.size(); k++)
            chk("en_reorder", 512'(pkt_order[base+k]), 512'(en_exp2[k]));

        // Reset during beat 2 of a 5-beat tenant-1 packet
        add_pkt(1, 5, 8'($urandom));
        base = acc_cnt[1];
        b = 0;
        while (acc_cnt[1] - base < 2 && b < 20) begin
            cycle();
            b++;
        end
        chk("rst_mid_acc", 512'(acc_cnt[1] - base), 512'(2));
        clk_line_rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        s_axis_tvalid = '0;
        cur_user = -1;
        cycle();
        chk("rstm_mvalid", 512'(m_axis_tvalid), 512'(0));
        chk("rstm_sready", 512'(s_axis_tready), 512'(0));
        chk("rstm_busy", 512'(busy), 512'(0));
        clk_line_rst = 1'b0;
        base = pkt_order.size();
        add_pkt(1, 2, 8'($urandom));
        add_pkt(0, 2, 8'($urandom));
        drain(100);
        chk("rstm_first", 512'(pkt_order[base]), 512'(0));
        chk("rstm_second", 512'(pkt_order[base+1]), 512'(1));

        // Random traffic: source gaps, 50% output backpressure
        gap_en = 1'b1;
        rmode = 1;
        for (int p = 0; p < 200; p++)
            add_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), 8'($urandom));
        drain(20000);
        gap_en = 1'b0;
        rmode = 0;
        m_axis_tready = 1'b1;
        repeat (4) cycle();
        chk("final_idle", 512'({busy, m_axis_tvalid}), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
